// File: rtl/ov7670_capture.sv
// OV7670 parallel-bus receiver: oversamples the camera bus in the xclk domain,
// pairs bytes into RGB555 words and emits linear frame-buffer writes with framing checks.
module ov7670_capture #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int ADDR_W      = 19,
  parameter int SYNC_STAGES = 2
) (
  input  logic              xclk,
  input  logic              reset_n,
  input  logic              p_clock,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        p_data,
  input  logic              cap_start,
  input  logic              cont_mode,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              frame_start,
  output logic              frame_done,
  output logic              busy,
  output logic              line_err,
  output logic              frame_err,
  output logic              phase_err
);

  localparam int XW = $clog2(H_ACTIVE + 2);
  localparam int YW = $clog2(V_ACTIVE + 2);
  localparam logic [XW-1:0] X_MAX = XW'(H_ACTIVE);
  localparam logic [XW-1:0] X_SAT = XW'(H_ACTIVE + 1);
  localparam logic [YW-1:0] Y_MAX = YW'(V_ACTIVE);
  localparam logic [YW-1:0] Y_SAT = YW'(V_ACTIVE + 1);

  typedef enum logic [1:0] {IDLE, ARMED, SYNC, ACTIVE} state_t;

  logic [SYNC_STAGES-1:0]      pclk_sr, vs_sr, href_sr;
  logic [SYNC_STAGES-1:0][7:0] data_sr;
  logic                        pclk_q1, vs_q1, href_smp_q;

  state_t              state_q;
  logic [XW-1:0]       x_q;
  logic [YW-1:0]       y_q;
  logic                phase_q;
  logic [7:0]          byte0_q;
  logic [ADDR_W-1:0]   addr_q, base_q;
  logic                wr_en_q, fs_q, fd_q, busy_q, lerr_q, ferr_q, perr_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [15:0]         wr_data_q;

  // All four camera signals share one delay so pclk edges line up with their data.
  logic       pclk_q0, vs_s, href_s;
  logic [7:0] data_s;
  assign pclk_q0 = pclk_sr[SYNC_STAGES-1];
  assign vs_s    = vs_sr[SYNC_STAGES-1];
  assign href_s  = href_sr[SYNC_STAGES-1];
  assign data_s  = data_sr[SYNC_STAGES-1];

  logic smp, vs_rise, vs_fall, line_end, byte_in, in_range;
  assign smp      = pclk_q1 & ~pclk_q0;
  assign vs_rise  = vs_s & ~vs_q1;
  assign vs_fall  = ~vs_s & vs_q1;
  assign line_end = smp & href_smp_q & ~href_s;
  assign byte_in  = smp & href_s;
  assign in_range = (x_q < X_MAX) && (y_q < Y_MAX);

  always_ff @(posedge xclk or negedge reset_n) begin
    if (!reset_n) begin
      pclk_sr    <= '0;
      vs_sr      <= '0;
      href_sr    <= '0;
      data_sr    <= '0;
      pclk_q1    <= 1'b0;
      vs_q1      <= 1'b0;
      href_smp_q <= 1'b0;
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      phase_q    <= 1'b0;
      byte0_q    <= '0;
      addr_q     <= '0;
      base_q     <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      fs_q       <= 1'b0;
      fd_q       <= 1'b0;
      busy_q     <= 1'b0;
      lerr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      pclk_sr <= {pclk_sr[SYNC_STAGES-2:0], p_clock};
      vs_sr   <= {vs_sr[SYNC_STAGES-2:0], vsync};
      href_sr <= {href_sr[SYNC_STAGES-2:0], href};
      data_sr <= {data_sr[SYNC_STAGES-2:0], p_data};
      pclk_q1 <= pclk_q0;
      vs_q1   <= vs_s;
      if (smp) href_smp_q <= href_s;
      wr_en_q <= 1'b0;
      fs_q    <= 1'b0;
      fd_q    <= 1'b0;

      case (state_q)
        IDLE: if (cap_start || cont_mode) begin
          state_q <= ARMED;
          busy_q  <= 1'b1;
        end
        ARMED: if (vs_rise) state_q <= SYNC;
        SYNC: if (vs_fall) begin
          fs_q    <= 1'b1;
          x_q     <= '0;
          y_q     <= '0;
          phase_q <= 1'b0;
          addr_q  <= '0;
          base_q  <= '0;
          lerr_q  <= 1'b0;
          ferr_q  <= 1'b0;
          perr_q  <= 1'b0;
          state_q <= ACTIVE;
        end
        ACTIVE: begin
          if (vs_rise) begin
            fd_q <= 1'b1;
            if (y_q != Y_MAX) ferr_q <= 1'b1;
            if (cont_mode) state_q <= SYNC;
            else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else if (line_end) begin
            if (phase_q) perr_q <= 1'b1;
            if (x_q != X_MAX) lerr_q <= 1'b1;
            if (y_q != Y_SAT) y_q <= y_q + YW'(1);
            x_q     <= '0;
            phase_q <= 1'b0;
            // Realign from the line base so a short line cannot skew later lines.
            if (y_q < Y_MAX) begin
              base_q <= base_q + ADDR_W'(H_ACTIVE);
              addr_q <= base_q + ADDR_W'(H_ACTIVE);
            end
          end else if (byte_in) begin
            if (!phase_q) begin
              byte0_q <= data_s;
              phase_q <= 1'b1;
            end else begin
              phase_q <= 1'b0;
              if (in_range) begin
                wr_en_q   <= 1'b1;
                wr_addr_q <= addr_q;
                wr_data_q <= {byte0_q, data_s};
                addr_q    <= addr_q + ADDR_W'(1);
              end
              if (x_q != X_SAT) x_q <= x_q + XW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign frame_start = fs_q;
  assign frame_done  = fd_q;
  assign busy        = busy_q;
  assign line_err    = lerr_q;
  assign frame_err   = ferr_q;
  assign phase_err   = perr_q;

endmodule
